// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide sequencer: opcodes, FSM states, counter width.
// OP_W is 4 because ten opcodes are defined; a 3-bit field cannot encode them all.
package md_pkg;

   localparam int CNT_W = 4;
   localparam int OP_W  = 4;

   typedef enum logic [OP_W-1:0] {
      MD_MULT  = 4'd0,
      MD_MULTU = 4'd1,
      MD_DIV   = 4'd2,
      MD_DIVU  = 4'd3,
      MD_MTHI  = 4'd4,
      MD_MTLO  = 4'd5,
      MD_MADD  = 4'd6,
      MD_MADDU = 4'd7,
      MD_MSUB  = 4'd8,
      MD_MSUBU = 4'd9
   } md_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_e;

endpackage

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer: computes the result at issue, holds it in temps for LAT cycles, then commits to HI/LO.
// Optional MD_SEQ_MADD_EN adds MADD/MADDU/MSUB/MSUBU (accumulate into HI:LO).
// Handshake: start is a one-cycle op-valid with no ready; the pipeline holds off new MD ops using
// stall_req, and any start seen while busy is dropped.
module md_sequencer
   import md_pkg::*;
#(
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
)
(
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [OP_W-1:0] op,
   input  logic [31:0]     a,
   input  logic [31:0]     b,
   input  logic            d_uses_md,
   output logic            busy,
   output logic            stall_req,
   output logic [31:0]     hi,
   output logic [31:0]     lo,
   output logic            done,
   output md_state_e       o_dbg_state
);

   localparam logic [CNT_W-1:0] MULT_CNT0 = CNT_W'(MULT_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_CNT0  = CNT_W'(DIV_LAT - 1);

   md_state_e        r_state, w_state_n;
   logic [CNT_W-1:0] r_cnt, w_cnt_n, w_cnt0;
   logic [31:0]      r_hi, r_lo, r_t_hi, r_t_lo;
   logic             w_is_long, w_launch, w_commit;
   logic [63:0]      w_res;

   logic signed [63:0] w_prod_s;
   logic [63:0]        w_prod_u;
   logic [31:0]        w_b_nz;
   logic signed [31:0] w_q_s, w_r_s;
   logic [31:0]        w_q_u, w_r_u;

   // Divisor forced non-zero so the divider never produces X; the b==0 result is discarded below.
   assign w_b_nz   = (b == 32'd0) ? 32'd1 : b;
   assign w_prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
   assign w_prod_u = {32'd0, a} * {32'd0, b};
   assign w_q_s    = $signed(a) / $signed(w_b_nz);
   assign w_r_s    = $signed(a) % $signed(w_b_nz);
   assign w_q_u    = a / w_b_nz;
   assign w_r_u    = a % w_b_nz;

   always_comb begin
      w_is_long = 1'b0;
      w_cnt0    = MULT_CNT0;
      w_res     = {r_hi, r_lo};
      case (op)
         MD_MULT:  begin w_is_long = 1'b1; w_res = $unsigned(w_prod_s); end
         MD_MULTU: begin w_is_long = 1'b1; w_res = w_prod_u; end
         MD_DIV: begin
            w_is_long = 1'b1;
            w_cnt0    = DIV_CNT0;
            if (b != 32'd0) w_res = {$unsigned(w_r_s), $unsigned(w_q_s)};
         end
         MD_DIVU: begin
            w_is_long = 1'b1;
            w_cnt0    = DIV_CNT0;
            if (b != 32'd0) w_res = {w_r_u, w_q_u};
         end
`ifdef MD_SEQ_MADD_EN
         MD_MADD:  begin w_is_long = 1'b1; w_res = {r_hi, r_lo} + $unsigned(w_prod_s); end
         MD_MADDU: begin w_is_long = 1'b1; w_res = {r_hi, r_lo} + w_prod_u; end
         MD_MSUB:  begin w_is_long = 1'b1; w_res = {r_hi, r_lo} - $unsigned(w_prod_s); end
         MD_MSUBU: begin w_is_long = 1'b1; w_res = {r_hi, r_lo} - w_prod_u; end
`endif
         default: ;
      endcase
   end

   always_comb begin
      w_state_n = r_state;
      w_cnt_n   = r_cnt;
      w_launch  = 1'b0;
      w_commit  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start && w_is_long) begin
               w_state_n = ST_RUN;
               w_cnt_n   = w_cnt0;
               w_launch  = 1'b1;
            end
         end
         ST_RUN: begin
            if (r_cnt == '0) begin
               w_state_n = ST_IDLE;
               w_commit  = 1'b1;
            end else begin
               w_cnt_n = r_cnt - 1'b1;
            end
         end
         default: w_state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_n;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt  <= '0;
         r_t_hi <= '0;
         r_t_lo <= '0;
         r_hi   <= '0;
         r_lo   <= '0;
      end else begin
         r_cnt <= w_cnt_n;
         if (w_launch) {r_t_hi, r_t_lo} <= w_res;
         if (w_commit) begin
            r_hi <= r_t_hi;
            r_lo <= r_t_lo;
         end else if (r_state == ST_IDLE && start) begin
            if (op == MD_MTHI) r_hi <= a;
            if (op == MD_MTLO) r_lo <= a;
         end
      end
   end

   assign busy        = (r_state == ST_RUN);
   assign done        = w_commit;
   assign stall_req   = d_uses_md & (busy | start);
   assign hi          = r_hi;
   assign lo          = r_lo;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed self-checking bench for md_sequencer; build with +define+MD_SEQ_MADD_EN to cover accumulate ops.
module tb_md_sequencer;
   import md_pkg::*;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            start = 1'b0;
   logic [OP_W-1:0] op = '0;
   logic [31:0]     a = '0;
   logic [31:0]     b = '0;
   logic            d_uses_md = 1'b0;
   logic            busy, stall_req, done;
   logic [31:0]     hi, lo;
   md_state_e       dbg_state;

   int checks = 0;
   int errors = 0;

   md_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .d_uses_md(d_uses_md), .busy(busy), .stall_req(stall_req),
      .hi(hi), .lo(lo), .done(done), .o_dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // Issuing while busy must never happen; the stall path is supposed to prevent it.
   always @(negedge clk) begin
      checks++;
      assert (!(start && busy)) else begin
         errors++;
         $error("FAIL start_while_busy obs=1 exp=0");
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic clk_step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [OP_W-1:0] f_op, input logic [31:0] f_a, input logic [31:0] f_b);
      start = 1'b1;
      op    = f_op;
      a     = f_a;
      b     = f_b;
      #1;
      chk("stall_issue", {31'd0, stall_req}, {31'd0, d_uses_md});
      clk_step();
      start = 1'b0;
      #1;
   endtask

   task automatic run(input string tag, input logic [OP_W-1:0] f_op, input logic [31:0] f_a,
                      input logic [31:0] f_b, input int lat,
                      input logic [31:0] old_hi, input logic [31:0] old_lo,
                      input logic [31:0] new_hi, input logic [31:0] new_lo);
      issue(f_op, f_a, f_b);
      for (int i = 0; i < lat; i++) begin
         chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
         chk({tag, "_done"}, {31'd0, done}, (i == lat - 1) ? 32'd1 : 32'd0);
         chk({tag, "_stall"}, {31'd0, stall_req}, {31'd0, d_uses_md});
         chk({tag, "_hi_hold"}, hi, old_hi);
         chk({tag, "_lo_hold"}, lo, old_lo);
         if (i < lat - 1) clk_step();
      end
      clk_step();
      chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
      chk({tag, "_done_end"}, {31'd0, done}, 32'd0);
      chk({tag, "_stall_end"}, {31'd0, stall_req}, 32'd0);
      chk({tag, "_hi"}, hi, new_hi);
      chk({tag, "_lo"}, lo, new_lo);
   endtask

   task automatic one_cycle(input string tag, input logic [OP_W-1:0] f_op, input logic [31:0] f_a,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      issue(f_op, f_a, 32'd3);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_done"}, {31'd0, done}, 32'd0);
      chk({tag, "_hi"}, hi, exp_hi);
      chk({tag, "_lo"}, lo, exp_lo);
   endtask

   initial begin
      repeat (3) clk_step();
      reset = 1'b0;
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_stall", {31'd0, stall_req}, 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      chk("rst_state", {31'd0, dbg_state}, {31'd0, ST_IDLE});

      run("mult", MD_MULT, 32'hFFFF_FFFD, 32'd7, 5, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 32'd1, 32'hFFFF_FFFE);
      run("divu", MD_DIVU, 32'd100, 32'd7, 10, 32'd1, 32'hFFFF_FFFE, 32'd2, 32'd14);
      run("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'd2, 32'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

      one_cycle("mthi", MD_MTHI, 32'd5, 32'd5, 32'hFFFF_FFFD);
      one_cycle("mtlo", MD_MTLO, 32'd9, 32'd5, 32'd9);
      run("div0", MD_DIV, 32'd123, 32'd0, 10, 32'd5, 32'd9, 32'd5, 32'd9);
      one_cycle("unk_op", 4'hF, 32'd77, 32'd5, 32'd9);

      d_uses_md = 1'b1;
      run("stall_mult", MD_MULT, 32'd4, 32'd5, 5, 32'd5, 32'd9, 32'd0, 32'd20);
      d_uses_md = 1'b0;

      one_cycle("mthi0", MD_MTHI, 32'd0, 32'd0, 32'd20);
      one_cycle("mtlo1", MD_MTLO, 32'd1, 32'd0, 32'd1);
`ifdef MD_SEQ_MADD_EN
      run("madd", MD_MADD, 32'd2, 32'd3, 5, 32'd0, 32'd1, 32'd0, 32'd7);
      run("msubu", MD_MSUBU, 32'd1, 32'd8, 5, 32'd0, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`else
      one_cycle("madd_off", MD_MADD, 32'd2, 32'd0, 32'd1);
      one_cycle("msubu_off", MD_MSUBU, 32'd1, 32'd0, 32'd1);
`endif

      one_cycle("mthi33", MD_MTHI, 32'h21, 32'h21, lo);
      issue(MD_DIV, 32'd50, 32'd5);
      clk_step();
      clk_step();
      reset = 1'b1;
      #1;
      chk("rstmid_busy_pre", {31'd0, busy}, 32'd1);
      chk("rstmid_done_pre", {31'd0, done}, 32'd0);
      clk_step();
      reset = 1'b0;
      #1;
      chk("rstmid_busy", {31'd0, busy}, 32'd0);
      chk("rstmid_done", {31'd0, done}, 32'd0);
      chk("rstmid_hi", hi, 32'd0);
      chk("rstmid_lo", lo, 32'd0);
      chk("rstmid_state", {31'd0, dbg_state}, {31'd0, ST_IDLE});
      for (int i = 0; i < 12; i++) begin
         clk_step();
         chk("post_rst_busy", {31'd0, busy}, 32'd0);
         chk("post_rst_done", {31'd0, done}, 32'd0);
      end

      run("mult_after_rst", MD_MULT, 32'd6, 32'hFFFF_FFFF, 5, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
